// File: rtl/uart_pkg.sv
// Types, constants and config-clamping helpers shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NO_PARITY   = 2'd0,
        EVEN_PARITY = 2'd1,
        ODD_PARITY  = 2'd2
    } parity_t;

    typedef enum logic [3:0] {
        TX_IDLE   = 4'd0,
        TX_START  = 4'd1,
        TX_DATA   = 4'd2,
        TX_PARITY = 4'd3,
        TX_STOP   = 4'd4
    } tx_state_t;

    localparam int UART_MIN_DW = 5;
    localparam int UART_MAX_DW = 8;

    function automatic logic [3:0] clamp_dw(input logic [3:0] dw);
        if (dw < 4'(UART_MIN_DW)) return 4'(UART_MIN_DW);
        if (dw > 4'(UART_MAX_DW)) return 4'(UART_MAX_DW);
        return dw;
    endfunction

    function automatic logic [1:0] clamp_sb(input logic [1:0] sb);
        if (sb == 2'd0) return 2'd1;
        if (sb >= 2'd2) return 2'd2;
        return sb;
    endfunction

    function automatic parity_t clamp_parity(input parity_t p);
        if (p == EVEN_PARITY || p == ODD_PARITY) return p;
        return NO_PARITY;
    endfunction

    // dw must already be clamped to 5..8
    function automatic logic [7:0] dw_mask(input logic [3:0] dw);
        return 8'hFF >> (4'd8 - dw);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..samples_per_bit-1 while running and flags the last clk of each bit.
module uart_bit_timer #(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    run,
    input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    output logic                    bit_end
);

    logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d;

    assign bit_end = run && (cnt_q == samples_per_bit - SAMPLE_WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_end) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + SAMPLE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_uart_if.sv
// UART transmitter: one word per valid/ready handshake, framed as start/data/parity/stop, LSB first.
module tx_uart_if
    import uart_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    input  logic [3:0]              data_width,
    input  logic [1:0]              stop_bits,
    input  parity_t                 parity,
    input  logic [7:0]              data,
    input  logic                    valid,
    output logic                    ready,
    output logic                    busy,
    output logic [3:0]              state_o,
    output logic                    tx_out
);

    tx_state_t               state_q, state_d;
    logic                    tx_out_q, tx_out_d;
    logic [7:0]              shreg_q, shreg_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [SAMPLE_WIDTH-1:0] spb_q, spb_d;
    logic [3:0]              dw_q, dw_d;
    logic [1:0]              sb_q, sb_d;
    parity_t                 par_q, par_d;
    logic                    par_bit_q, par_bit_d;

    logic       bit_end;
    logic       last_stop;
    logic       accept;
    logic [3:0] dw_clamped;
    parity_t    par_clamped;
    logic [7:0] data_masked;

    uart_bit_timer #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_bit_timer (
        .clk             (clk),
        .reset           (reset),
        .clear           (accept || state_q == TX_IDLE),
        .run             (state_q != TX_IDLE),
        .samples_per_bit (spb_q),
        .bit_end         (bit_end)
    );

    // Accepting in the final clk of the last stop bit gives gap-free back-to-back frames
    assign last_stop = (state_q == TX_STOP) && bit_end && ({1'b0, stop_cnt_q} == sb_q - 2'd1);
    assign ready     = enable && !reset && (state_q == TX_IDLE || last_stop);
    assign accept    = valid && ready;

    assign dw_clamped  = clamp_dw(data_width);
    assign par_clamped = clamp_parity(parity);
    assign data_masked = data & dw_mask(dw_clamped);

    assign busy    = (state_q != TX_IDLE);
    assign state_o = state_q;
    assign tx_out  = tx_out_q;

    always_comb begin
        state_d    = state_q;
        tx_out_d   = tx_out_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        spb_d      = spb_q;
        dw_d       = dw_q;
        sb_d       = sb_q;
        par_d      = par_q;
        par_bit_d  = par_bit_q;

        case (state_q)
            TX_IDLE: begin
                tx_out_d = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    tx_out_d  = shreg_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if ({1'b0, bit_cnt_q} == dw_q - 4'd1) begin
                        if (par_q != NO_PARITY) begin
                            state_d  = TX_PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d    = TX_STOP;
                            tx_out_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        tx_out_d  = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (bit_end) begin
                    state_d    = TX_STOP;
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_d  = TX_IDLE;
                        tx_out_d = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = TX_IDLE;
                tx_out_d = 1'b1;
            end
        endcase

        // Config and data are captured only here, so mid-frame input changes wait for the next frame
        if (accept) begin
            state_d   = TX_START;
            tx_out_d  = 1'b0;
            spb_d     = (samples_per_bit == '0) ? SAMPLE_WIDTH'(1) : samples_per_bit;
            dw_d      = dw_clamped;
            sb_d      = clamp_sb(stop_bits);
            par_d     = par_clamped;
            shreg_d   = data_masked;
            par_bit_d = (par_clamped == ODD_PARITY) ? ~^data_masked : ^data_masked;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            tx_out_q   <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            spb_q      <= '0;
            dw_q       <= '0;
            sb_q       <= '0;
            par_q      <= NO_PARITY;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_out_q   <= tx_out_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            spb_q      <= spb_d;
            dw_q       <= dw_d;
            sb_q       <= sb_d;
            par_q      <= par_d;
            par_bit_q  <= par_bit_d;
        end
    end

endmodule
